samsung_ir_rx: RTL and testbench
================================

SAMSUNG_IR_RX -- requirements
Module: samsung_ir_rx

Interface
REQ-001 SHALL have parameter LEAD_MARK, default 225000; leader mark nominal length in clk cycles.
REQ-002 SHALL have parameter LEAD_SPACE, default 225000; leader space nominal length in cycles.
REQ-003 SHALL have parameter BIT_MARK, default 28000; data/stop mark nominal length in cycles.
REQ-004 SHALL have parameter SPACE0, default 28000; nominal space for a 0 bit.
REQ-005 SHALL have parameter SPACE1, default 84500; nominal space for a 1 bit.
REQ-006 SHALL have parameter TOL_SHIFT, default 2; tolerance is nominal>>TOL_SHIFT.
REQ-007 SHALL have port clk, input, 1; clock, all logic on posedge.
REQ-008 SHALL have port reset, input, 1; reset, synchronous, active-high.
REQ-009 SHALL have port ir_in, input, 1; asynchronous demodulated IR line, 1 = mark.
REQ-010 SHALL have port cmd_out, output, 32; last successfully decoded frame, first received bit in bit 31.
REQ-011 SHALL have port cmd_valid, output, 1; one-cycle pulse when cmd_out updates.
REQ-012 SHALL have port frame_err, output, 1; one-cycle pulse on any decode failure.

Function
REQ-013 SHALL pass ir_in through a 2-flop synchronizer plus 1 delay flop; edges detected on synchronized signal (3-cycle input latency).
REQ-014 SHALL measure each mark/space with a 32-bit counter, cleared on every accepted edge, saturating at all-ones.
REQ-015 SHALL accept a duration d for nominal N iff N-(N>>TOL_SHIFT) <= d <= N+(N>>TOL_SHIFT).
REQ-016 SHALL implement states IDLE, LEAD_MK, LEAD_SP, BIT_MK, BIT_SP.
REQ-017 IDLE: rising edge -> LEAD_MK; falling edges ignored.
REQ-018 LEAD_MK: falling edge with count in LEAD_MARK window -> LEAD_SP, else error.
REQ-019 LEAD_SP: rising edge in LEAD_SPACE window -> BIT_MK with bit index 0, else error.
REQ-020 BIT_MK: falling edge in BIT_MARK window -> BIT_SP if bit index < 32; if index == 32 (stop mark) -> frame complete, IDLE; else error.
REQ-021 BIT_SP: rising edge in SPACE0 window shifts 0 in, SPACE1 window shifts 1 in (left shift, LSB entry), index+1 -> BIT_MK; other durations -> error.
REQ-022 SHALL raise error immediately (timeout) when count exceeds the upper bound of the longest acceptable window of the current state, without waiting for an edge.
REQ-023 Error: frame_err pulses 1 cycle, shift register discarded, cmd_out unchanged, state -> IDLE.
REQ-024 Frame complete: cmd_out <= shift register and cmd_valid pulses in the same cycle, 1 cycle after the stop-mark falling edge is detected.
REQ-025 cmd_valid and frame_err SHALL never assert in the same cycle.

Reset
REQ-026 reset SHALL have priority over all events: state IDLE, counter 0, bit index 0, synchronizer flops 0, shift register 0, cmd_out 0, cmd_valid 0, frame_err 0.
REQ-027 Reset mid-frame SHALL abandon the frame with no cmd_valid and no frame_err; a line already high at release is treated as a fresh rising edge.

Configuration
REQ-028 Macro SAMSUNG_RX_CHECK_EN: when defined, a completed frame whose bits[7:0] != ~bits[15:8] SHALL give frame_err instead of cmd_valid, cmd_out unchanged.
REQ-029 Without SAMSUNG_RX_CHECK_EN every structurally valid 32-bit frame SHALL be accepted.

Structure
REQ-030 Package samsung_ir_pkg SHALL hold the state enum typedef and the default timing constants shared with the transmitter.
REQ-031 Sub-module ir_sync SHALL contain the synchronizer and rise/fall edge detection.

Verification
REQ-032 Transmitter instance sends 0xF0F0F0F0 -> cmd_out=0xF0F0F0F0, exactly one cmd_valid, no frame_err.
REQ-033 Leader mark of 100000 cycles -> frame_err once, no cmd_valid, next good frame 0x12345678 decodes correctly.
REQ-034 Data space of 56000 cycles at bit 5 -> frame_err; space held low 120000 cycles -> frame_err by timeout before the next edge.
REQ-035 Reset asserted during bit 10 -> no cmd_valid/frame_err; following frame 0xE0E040BF decodes.
REQ-036 SAMSUNG_RX_CHECK_EN defined: 0xE0E040BF -> cmd_valid; 0xE0E040BE -> frame_err; macro undefined: both give cmd_valid.

Source files
------------

// File: rtl/samsung_ir_pkg.sv
// Shared types and default timing for the Samsung IR receiver/transmitter.
// Tolerance window helpers used by the receiver.
package samsung_ir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MK,
        LEAD_SP,
        BIT_MK,
        BIT_SP
    } state_e;

    localparam int unsigned DEF_LEAD_MARK  = 225000;
    localparam int unsigned DEF_LEAD_SPACE = 225000;
    localparam int unsigned DEF_BIT_MARK   = 28000;
    localparam int unsigned DEF_SPACE0     = 28000;
    localparam int unsigned DEF_SPACE1     = 84500;
    localparam int unsigned DEF_TOL_SHIFT  = 2;

    localparam logic [5:0] FRAME_BITS = 6'd32;

    function automatic logic [31:0] win_lo(input logic [31:0] n,
                                           input int unsigned sh);
        return n - (n >> sh);
    endfunction

    function automatic logic [31:0] win_hi(input logic [31:0] n,
                                           input int unsigned sh);
        return n + (n >> sh);
    endfunction

    function automatic logic [31:0] max32(input logic [31:0] a,
                                          input logic [31:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/samsung_ir_rx_if.sv
// Bundle of the IR line and the decoded-command outputs.
// master = receiver side, slave = consumer/stimulus side.
interface samsung_ir_rx_if;
    logic        ir_in;
    logic [31:0] cmd_out;
    logic        cmd_valid;
    logic        frame_err;

    modport master (
        input  ir_in,
        output cmd_out,
        output cmd_valid,
        output frame_err
    );

    modport slave (
        output ir_in,
        input  cmd_out,
        input  cmd_valid,
        input  frame_err
    );
endinterface

// File: rtl/samsung_ir_rx_ir_sync.sv
// Two-flop synchronizer plus one delay flop for the IR line,
// with rise/fall detection on the synchronized level.
module ir_sync (
    input  logic clk,
    input  logic reset,
    input  logic ir_i,
    output logic rise_o,
    output logic fall_o
);
    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= ir_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_o = s2_q & ~s3_q;
    assign fall_o = ~s2_q & s3_q;
endmodule

// File: rtl/samsung_ir_rx.sv
// Samsung IR frame decoder: leader, 32 pulse-distance bits, stop mark.
// Optional SAMSUNG_RX_CHECK_EN rejects frames whose last byte is not ~byte 1.
module samsung_ir_rx
    import samsung_ir_pkg::*;
#(
    parameter int unsigned LEAD_MARK  = DEF_LEAD_MARK,
    parameter int unsigned LEAD_SPACE = DEF_LEAD_SPACE,
    parameter int unsigned BIT_MARK   = DEF_BIT_MARK,
    parameter int unsigned SPACE0     = DEF_SPACE0,
    parameter int unsigned SPACE1     = DEF_SPACE1,
    parameter int unsigned TOL_SHIFT  = DEF_TOL_SHIFT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ir_in,
    output logic [31:0] cmd_out,
    output logic        cmd_valid,
    output logic        frame_err
);
    localparam logic [31:0] LM_LO = win_lo(LEAD_MARK, TOL_SHIFT);
    localparam logic [31:0] LM_HI = win_hi(LEAD_MARK, TOL_SHIFT);
    localparam logic [31:0] LS_LO = win_lo(LEAD_SPACE, TOL_SHIFT);
    localparam logic [31:0] LS_HI = win_hi(LEAD_SPACE, TOL_SHIFT);
    localparam logic [31:0] BM_LO = win_lo(BIT_MARK, TOL_SHIFT);
    localparam logic [31:0] BM_HI = win_hi(BIT_MARK, TOL_SHIFT);
    localparam logic [31:0] S0_LO = win_lo(SPACE0, TOL_SHIFT);
    localparam logic [31:0] S0_HI = win_hi(SPACE0, TOL_SHIFT);
    localparam logic [31:0] S1_LO = win_lo(SPACE1, TOL_SHIFT);
    localparam logic [31:0] S1_HI = win_hi(SPACE1, TOL_SHIFT);
    localparam logic [31:0] SP_HI = max32(S0_HI, S1_HI);

    state_e      state_q;
    logic [31:0] cnt_q, cnt_d;
    logic [5:0]  idx_q;
    logic [31:0] sr_q;
    logic [31:0] cmd_q;
    logic        valid_q, err_q;

    logic rise, fall;
    logic in_lm, in_ls, in_bm, in_s0, in_s1;
    logic evt, ok, over, bad, chk_ok;

    ir_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .ir_i   (ir_in),
        .rise_o (rise),
        .fall_o (fall)
    );

    assign in_lm = (cnt_q >= LM_LO) && (cnt_q <= LM_HI);
    assign in_ls = (cnt_q >= LS_LO) && (cnt_q <= LS_HI);
    assign in_bm = (cnt_q >= BM_LO) && (cnt_q <= BM_HI);
    assign in_s0 = (cnt_q >= S0_LO) && (cnt_q <= S0_HI);
    assign in_s1 = (cnt_q >= S1_LO) && (cnt_q <= S1_HI);

`ifdef SAMSUNG_RX_CHECK_EN
    assign chk_ok = (sr_q[7:0] == ~sr_q[15:8]);
`else
    assign chk_ok = 1'b1;
`endif

    always_comb begin
        cnt_d = cnt_q;
        if (rise || fall) begin
            cnt_d = '0;
        end else if (!(&cnt_q)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // evt: the edge that ends the current interval; over: timeout
    always_comb begin
        evt  = 1'b0;
        ok   = 1'b0;
        over = 1'b0;
        unique case (state_q)
            IDLE: begin
                evt = rise;
                ok  = 1'b1;
            end
            LEAD_MK: begin
                evt  = fall;
                ok   = in_lm;
                over = cnt_q > LM_HI;
            end
            LEAD_SP: begin
                evt  = rise;
                ok   = in_ls;
                over = cnt_q > LS_HI;
            end
            BIT_MK: begin
                evt  = fall;
                ok   = in_bm;
                over = cnt_q > BM_HI;
            end
            BIT_SP: begin
                evt  = rise;
                ok   = in_s0 | in_s1;
                over = cnt_q > SP_HI;
            end
            default: begin
                evt  = 1'b0;
                ok   = 1'b0;
                over = 1'b1;
            end
        endcase
        bad = over | (evt & ~ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sr_q    <= '0;
            cmd_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (bad) begin
                err_q   <= 1'b1;
                state_q <= IDLE;
                idx_q   <= '0;
                sr_q    <= '0;
            end else if (evt) begin
                unique case (state_q)
                    IDLE: begin
                        state_q <= LEAD_MK;
                        idx_q   <= '0;
                        sr_q    <= '0;
                    end
                    LEAD_MK: state_q <= LEAD_SP;
                    LEAD_SP: begin
                        state_q <= BIT_MK;
                        idx_q   <= '0;
                    end
                    BIT_MK: begin
                        if (idx_q == FRAME_BITS) begin
                            state_q <= IDLE;
                            idx_q   <= '0;
                            sr_q    <= '0;
                            if (chk_ok) begin
                                cmd_q   <= sr_q;
                                valid_q <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end else begin
                            state_q <= BIT_SP;
                        end
                    end
                    BIT_SP: begin
                        state_q <= BIT_MK;
                        idx_q   <= idx_q + 6'd1;
                        sr_q    <= {sr_q[30:0], ~in_s0};
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign cmd_out   = cmd_q;
    assign cmd_valid = valid_q;
    assign frame_err = err_q;
endmodule

// File: tb/tb_samsung_ir_rx.sv
// Directed bench for samsung_ir_rx with timing scaled down by 1000.
// Expected frames and pulse counts are written out by hand per test.
module tb_samsung_ir_rx;
    localparam int LM = 225;
    localparam int LS = 225;
    localparam int BM = 28;
    localparam int S0 = 28;
    localparam int S1 = 85;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_tests = 0;
    int n_fail = 0;
    int val_cnt = 0;
    int err_cnt = 0;
    int v0, e0;

    samsung_ir_rx_if bus ();

    samsung_ir_rx #(
        .LEAD_MARK  (LM),
        .LEAD_SPACE (LS),
        .BIT_MARK   (BM),
        .SPACE0     (S0),
        .SPACE1     (S1),
        .TOL_SHIFT  (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ir_in     (bus.ir_in),
        .cmd_out   (bus.cmd_out),
        .cmd_valid (bus.cmd_valid),
        .frame_err (bus.frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.cmd_valid) val_cnt++;
            if (bus.frame_err) err_cnt++;
            if (bus.cmd_valid || bus.frame_err)
                check("excl", {31'd0, bus.cmd_valid & bus.frame_err}, 32'd0);
        end
    end

    task automatic drive(input logic v, input int n);
        bus.ir_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_head(input logic [31:0] f, input int nb,
                             input int lead, input int s0, input int s1);
        drive(1'b1, lead);
        drive(1'b0, LS);
        for (int i = 0; i < nb; i++) begin
            drive(1'b1, BM);
            drive(1'b0, f[31-i] ? s1 : s0);
        end
    endtask

    task automatic send_frame(input logic [31:0] f, input int s0,
                              input int s1);
        send_head(f, 32, LM, s0, s1);
        drive(1'b1, BM);
        drive(1'b0, 40);
    endtask

    task automatic mark_start;
        v0 = val_cnt;
        e0 = err_cnt;
    endtask

    initial begin
        bus.ir_in = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_cmd", bus.cmd_out, 32'h0);
        check("rst_val", {31'd0, bus.cmd_valid}, 32'd0);
        check("rst_err", {31'd0, bus.frame_err}, 32'd0);
        reset = 1'b0;
        drive(1'b0, 20);

        mark_start();
        send_frame(32'hF0F0F0F0, S0, S1);
        check("f0_cmd", bus.cmd_out, 32'hF0F0F0F0);
        check("f0_val", val_cnt - v0, 1);
        check("f0_err", err_cnt - e0, 0);

        mark_start();
        drive(1'b1, 100);
        drive(1'b0, 60);
        check("lead_err", err_cnt - e0, 1);
        check("lead_val", val_cnt - v0, 0);
        check("lead_cmd", bus.cmd_out, 32'hF0F0F0F0);
        mark_start();
        send_frame(32'h12345678, S0, S1);
        check("f1_cmd", bus.cmd_out, 32'h12345678);
        check("f1_val", val_cnt - v0, 1);
        check("f1_err", err_cnt - e0, 0);

        mark_start();
        send_frame(32'h0F0F55AA, 23, 100);
        check("tol_cmd", bus.cmd_out, 32'h0F0F55AA);
        check("tol_val", val_cnt - v0, 1);
        check("tol_err", err_cnt - e0, 0);

        mark_start();
        send_head(32'hA5A5A5A5, 5, LM, S0, S1);
        drive(1'b1, BM);
        drive(1'b0, 56);
        drive(1'b1, 8);
        check("sp_err", err_cnt - e0, 1);
        check("sp_val", val_cnt - v0, 0);
        check("sp_cmd", bus.cmd_out, 32'h0F0F55AA);
        drive(1'b1, BM);
        drive(1'b0, 400);

        mark_start();
        send_head(32'hFFFF0000, 3, LM, S0, S1);
        drive(1'b1, BM);
        drive(1'b0, 100);
        check("tmo_early", err_cnt - e0, 0);
        drive(1'b0, 20);
        check("tmo_err", err_cnt - e0, 1);
        check("tmo_val", val_cnt - v0, 0);
        check("tmo_cmd", bus.cmd_out, 32'h0F0F55AA);
        drive(1'b0, 100);

        mark_start();
        send_head(32'hCAFEBABE, 10, LM, S0, S1);
        drive(1'b1, BM);
        drive(1'b0, 10);
        reset = 1'b1;
        drive(1'b0, 3);
        reset = 1'b0;
        drive(1'b0, 300);
        check("mid_rst_val", val_cnt - v0, 0);
        check("mid_rst_err", err_cnt - e0, 0);
        check("mid_rst_cmd", bus.cmd_out, 32'h0);
        mark_start();
        send_frame(32'hE0E040BF, S0, S1);
        check("f2_cmd", bus.cmd_out, 32'hE0E040BF);
        check("f2_val", val_cnt - v0, 1);
        check("f2_err", err_cnt - e0, 0);

        mark_start();
        send_frame(32'hE0E040BE, S0, S1);
`ifdef SAMSUNG_RX_CHECK_EN
        check("f3_cmd", bus.cmd_out, 32'hE0E040BF);
        check("f3_val", val_cnt - v0, 0);
        check("f3_err", err_cnt - e0, 1);
`else
        check("f3_cmd", bus.cmd_out, 32'hE0E040BE);
        check("f3_val", val_cnt - v0, 1);
        check("f3_err", err_cnt - e0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
